data_mem_resp: RTL and testbench
================================

Name: data_mem_resp

Overview:
- Data-memory responder: the slave end of the ram_rd/ram_wr strobe interface driven by the CPU control FSM during its MEMORY_ACCESS phase.
- Accepts single-word 16-bit read/write requests and holds a word-addressed RAM array.
- Returns read data or write completion after a fixed, parameterised latency, with a one-cycle ack pulse.
- Flags illegal requests.

Parameters:
- ADDR_W, 8, width of the internal word index.
- DEPTH, 256, number of 16-bit words implemented (≤ 2^ADDR_W).
- RD_LAT, 2, cycles from accept edge to read ack (legal 1..4).
- WR_LAT, 1, cycles from accept edge to write ack/commit (legal 1..4).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- ram_rd  in  1  read request strobe, sampled on rising clk.
- ram_wr  in  1  write request strobe, sampled on rising clk.
- ram_addr  in  16  word address (ALU result rs+offset).
- ram_wdata  in  16  write data (rt value), sampled with ram_wr.
- ram_rdata  out  16  read data, valid while ram_ack=1 on a read; held otherwise.
- ram_ack  out  1  one-cycle completion pulse.
- ram_busy  out  1  request in flight; new strobes ignored.
- ram_err  out  1  one-cycle error pulse.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; ram_rdata=0, ram_ack=0, ram_busy=0, ram_err=0; latency counter=0.
  - Array contents are not reset.
  - Reset mid-operation aborts the request: no ack, and an uncommitted write is discarded.
- States: IDLE, RD_WAIT, WR_WAIT, RESP.
- Accept condition:
  - The block accepts on a rising edge where state is IDLE or RESP, and exactly one of ram_rd/ram_wr is 1.
  - On accept it latches ram_addr and ram_wdata and sets the counter to LAT-1, where LAT is RD_LAT for reads and WR_LAT for writes.
- Accept transitions:
  - If LAT=1: go directly to RESP.
  - Otherwise: go to RD_WAIT or WR_WAIT.
- Wait states:
  - The counter decrements each cycle.
  - When the counter reaches 1, the next edge enters RESP.
  - Ack therefore rises exactly LAT cycles after the accept edge.
- RESP (exactly one cycle):
  - ram_ack=1.
  - Read: ram_rdata=mem[addr] (registered on the edge entering RESP).
  - Write: mem[addr]<=wdata on the edge entering RESP.
  - Next state: the accept target if a new request is present, else IDLE. Back-to-back throughput is one request per LAT+1 cycles at worst and per LAT cycles when chained from RESP.
- ram_busy:
  - 1 in RD_WAIT/WR_WAIT; 0 in IDLE/RESP.
  - Strobes arriving while busy=1 are dropped silently: no err, no ack.
- Simultaneous ram_rd=1 and ram_wr=1 in an accept state:
  - Not accepted; no array access; no ack.
  - ram_err=1 for the following cycle; state goes to IDLE.
- Out of range (ram_addr ≥ DEPTH, full 16-bit compare):
  - Accepted and timed normally.
  - In RESP: ram_ack=1 and ram_err=1 together. Read returns ram_rdata=0; write is discarded.
- Ordering:
  - A read accepted in the RESP cycle of a write to the same address returns the new data, since the commit precedes the read by ≥1 edge.
  - Reading an address never written returns array garbage (X in sim); benches must initialise before use.
- ram_rdata holds its last read value through writes and idle cycles.

Test Plan:
- Reset, then write 0xBEEF to addr 0x0010 (WR_LAT=1) -> ack 1 cycle after accept, busy stays 0; then read 0x0010 (RD_LAT=2) -> busy=1 for 1 cycle, ack and ram_rdata=0xBEEF exactly 2 cycles after accept.
- Back-to-back: write 0x1234 to addr 5, with a read of addr 5 issued in the write's RESP cycle -> read accepted immediately, returns 0x1234; no dropped request.
- ram_rd=ram_wr=1 at addr 3 -> no ack, ram_err=1 for one cycle, mem[3] unchanged (verify by readback).
- Read 0x0100 with DEPTH=256 -> ack and err together at RD_LAT, ram_rdata=0x0000; write 0xFFFF to 0x0100 -> ack+err, and later readbacks of 0x0000-0x00FF are unchanged.
- ram_wr strobe while busy=1 (RD_LAT=4, read in flight) -> strobe ignored, only the read ack appears, target word unchanged.
- Write with WR_LAT=3, assert rst one cycle after accept -> all outputs 0 immediately (asynchronous), no ack, and readback of the target address after reset shows the old value.

Source files
------------

// File: rtl/data_mem_resp.sv
// rtl/data_mem_resp.sv - word-addressed data-memory responder behind the ram_rd/ram_wr strobe interface
//
// Purpose:
//   Slave end of the CPU's MEMORY_ACCESS strobes. Accepts one 16-bit read or
//   write at a time and completes it after a fixed latency (RD_LAT / WR_LAT).
//   Completion is a one-cycle ram_ack pulse. Illegal requests raise ram_err.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   ram_rd     in   read request strobe
//   ram_wr     in   write request strobe
//   ram_addr   in   16-bit word address (full width checked against DEPTH)
//   ram_wdata  in   write data, sampled together with ram_wr
//   ram_rdata  out  read data, valid with ram_ack on a read, held otherwise
//   ram_ack    out  one-cycle completion pulse
//   ram_busy   out  request in flight; strobes are dropped while high
//   ram_err    out  one-cycle error pulse (both strobes, or address >= DEPTH)

module data_mem_resp #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256,
    parameter int RD_LAT = 2,
    parameter int WR_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ram_rd,
    input  logic        ram_wr,
    input  logic [15:0] ram_addr,
    input  logic [15:0] ram_wdata,
    output logic [15:0] ram_rdata,
    output logic        ram_ack,
    output logic        ram_busy,
    output logic        ram_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2,
        RESP    = 2'd3
    } state_t;

    // DEPTH is compared against the full 16-bit address; one extra bit keeps
    // DEPTH = 65536 representable.
    localparam logic [16:0] DEPTH_L = 17'(DEPTH);
    localparam logic [2:0]  RD_L    = 3'(RD_LAT);
    localparam logic [2:0]  WR_L    = 3'(WR_LAT);

    state_t      state;
    state_t      state_n;
    logic [2:0]  cnt;
    logic [2:0]  cnt_n;
    logic [15:0] addr_q;
    logic [15:0] wdata_q;
    logic        oor_q;
    logic        err_q;

    logic [15:0] mem [DEPTH];

    logic        accept_st;
    logic        req_both;
    logic        accept;
    logic [2:0]  lat_sel;
    logic        enter_resp;
    logic        resp_from_in;
    logic        resp_rd;
    logic [15:0] resp_addr;
    logic [15:0] resp_wdata;
    logic        resp_oor;
    logic [ADDR_W-1:0] resp_idx;

    // A new request may be taken while idle or while the previous one is
    // being acknowledged, which gives the LAT-cycle chained throughput.
    assign accept_st = (state == IDLE) || (state == RESP);
    assign req_both  = ram_rd & ram_wr;
    assign accept    = accept_st & (ram_rd ^ ram_wr);
    assign lat_sel   = ram_rd ? RD_L : WR_L;

    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        enter_resp   = 1'b0;
        resp_from_in = 1'b0;
        case (state)
            IDLE, RESP: begin
                if (accept) begin
                    if (lat_sel == 3'd1) begin
                        // Single-cycle latency: the access happens on the
                        // accept edge itself, straight from the input pins.
                        state_n      = RESP;
                        enter_resp   = 1'b1;
                        resp_from_in = 1'b1;
                    end else begin
                        state_n = ram_rd ? RD_WAIT : WR_WAIT;
                        cnt_n   = lat_sel - 3'd1;
                    end
                end else begin
                    // Covers "no request" and the illegal both-strobes case.
                    state_n = IDLE;
                end
            end
            RD_WAIT, WR_WAIT: begin
                cnt_n = cnt - 3'd1;
                if (cnt == 3'd1) begin
                    state_n    = RESP;
                    enter_resp = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Request attributes used on the edge that enters RESP.
    assign resp_rd    = resp_from_in ? ram_rd    : (state == RD_WAIT);
    assign resp_addr  = resp_from_in ? ram_addr  : addr_q;
    assign resp_wdata = resp_from_in ? ram_wdata : wdata_q;
    assign resp_oor   = ({1'b0, resp_addr} >= DEPTH_L);
    assign resp_idx   = resp_addr[ADDR_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 3'd0;
            addr_q    <= 16'd0;
            wdata_q   <= 16'd0;
            oor_q     <= 1'b0;
            err_q     <= 1'b0;
            ram_rdata <= 16'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            err_q <= accept_st & req_both;
            if (accept) begin
                addr_q  <= ram_addr;
                wdata_q <= ram_wdata;
            end
            if (enter_resp) begin
                oor_q <= resp_oor;
                if (resp_rd) begin
                    ram_rdata <= resp_oor ? 16'd0 : mem[resp_idx];
                end
            end
        end
    end

    // Array has no reset. The rst gate stops a single-cycle write whose
    // strobe coincides with reset; longer writes are already aborted because
    // reset forces the state back to IDLE before the commit edge.
    always_ff @(posedge clk) begin
        if (!rst && enter_resp && !resp_rd && !resp_oor) begin
            mem[resp_idx] <= resp_wdata;
        end
    end

    assign ram_ack  = (state == RESP);
    assign ram_busy = (state == RD_WAIT) || (state == WR_WAIT);
    assign ram_err  = err_q | ((state == RESP) & oor_q);

endmodule

// File: tb/tb_data_mem_resp.sv
// tb/tb_data_mem_resp.sv - scoreboard bench for data_mem_resp (two latency configurations)

module tb_data_mem_resp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, rst_b, sel, rd_i, wr_i;
    logic [15:0] addr_i, wdata_i;

    logic [15:0] a_rdata, b_rdata;
    logic        a_ack, a_busy, a_err, b_ack, b_busy, b_err;

    // Instance A: RD_LAT=2, WR_LAT=1. Instance B: RD_LAT=4, WR_LAT=3.
    data_mem_resp #(.RD_LAT(2), .WR_LAT(1)) dut_a (
        .clk(clk), .rst(rst_a),
        .ram_rd(rd_i & ~sel), .ram_wr(wr_i & ~sel),
        .ram_addr(addr_i), .ram_wdata(wdata_i),
        .ram_rdata(a_rdata), .ram_ack(a_ack), .ram_busy(a_busy), .ram_err(a_err)
    );

    data_mem_resp #(.RD_LAT(4), .WR_LAT(3)) dut_b (
        .clk(clk), .rst(rst_b),
        .ram_rd(rd_i & sel), .ram_wr(wr_i & sel),
        .ram_addr(addr_i), .ram_wdata(wdata_i),
        .ram_rdata(b_rdata), .ram_ack(b_ack), .ram_busy(b_busy), .ram_err(b_err)
    );

    logic [15:0] o_rdata;
    logic        o_ack, o_busy, o_err;
    assign o_rdata = sel ? b_rdata : a_rdata;
    assign o_ack   = sel ? b_ack   : a_ack;
    assign o_busy  = sel ? b_busy  : a_busy;
    assign o_err   = sel ? b_err   : a_err;

    typedef struct {
        logic [15:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sbq[$];
    logic [15:0] mdl [2][256];
    logic [15:0] lastd [2];
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int lat_of(input logic rd);
        if (sel) return rd ? 4 : 3;
        return rd ? 2 : 1;
    endfunction

    // Drive one request at the current negedge and push its expected response.
    task automatic issue(input logic rd, input logic wr, input logic [15:0] ad, input logic [15:0] wd);
        exp_t e;
        e.err = (ad >= 16'd256);
        if (rd) begin
            e.rdata = e.err ? 16'd0 : mdl[sel][ad[7:0]];
            lastd[sel] = e.rdata;
        end else begin
            e.rdata = lastd[sel];
            if (!e.err) mdl[sel][ad[7:0]] = wd;
        end
        sbq.push_back(e);
        rd_i = rd; wr_i = wr; addr_i = ad; wdata_i = wd;
    endtask

    task automatic step_clear();
        @(negedge clk);
        rd_i = 1'b0;
        wr_i = 1'b0;
    endtask

    // Called at negedge number 'first' after the accept edge; ack must appear
    // exactly at negedge 'lat'.
    task automatic wait_resp(input int lat, input int first);
        exp_t e;
        for (int n = first; n <= lat; n++) begin
            if (n > first) @(negedge clk);
            if (n < lat) begin
                chk("busy_wait", o_busy, 1);
                chk("ack_early", o_ack, 0);
            end else begin
                chk("ack", o_ack, 1);
                chk("busy_resp", o_busy, 0);
                chk("sb_size", sbq.size(), 1);
                if (sbq.size() > 0) begin
                    e = sbq.pop_front();
                    chk("rdata", o_rdata, e.rdata);
                    chk("err", o_err, e.err);
                end
            end
        end
    endtask

    task automatic op(input logic rd, input logic wr, input logic [15:0] ad, input logic [15:0] wd);
        issue(rd, wr, ad, wd);
        step_clear();
        wait_resp(lat_of(rd), 1);
        @(negedge clk);
        chk("ack_pulse", o_ack, 0);
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; sel = 1'b0;
        rd_i = 1'b0; wr_i = 1'b0; addr_i = 16'd0; wdata_i = 16'd0;
        lastd[0] = 16'd0; lastd[1] = 16'd0;
        @(negedge clk);
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            chk("rst_rdata", o_rdata, 0);
            chk("rst_ack", o_ack, 0);
            chk("rst_busy", o_busy, 0);
            chk("rst_err", o_err, 0);
        end
        sel = 1'b0;
        @(negedge clk);
        rst_a = 1'b0; rst_b = 1'b0;

        // Instance A: fill the whole array so every later read is defined.
        for (int i = 0; i < 256; i++) op(1'b0, 1'b1, 16'(i), 16'($urandom));

        op(1'b0, 1'b1, 16'h0010, 16'hBEEF);
        op(1'b1, 1'b0, 16'h0010, 16'h0000);

        // Write then read the same word chained from the write's RESP cycle.
        issue(1'b0, 1'b1, 16'h0005, 16'h1234);
        step_clear();
        wait_resp(1, 1);
        issue(1'b1, 1'b0, 16'h0005, 16'h0000);
        step_clear();
        wait_resp(2, 1);
        @(negedge clk);
        chk("chain_ack_pulse", o_ack, 0);

        // Both strobes together.
        rd_i = 1'b1; wr_i = 1'b1; addr_i = 16'h0003; wdata_i = 16'h0BAD;
        step_clear();
        chk("both_err", o_err, 1);
        chk("both_ack", o_ack, 0);
        chk("both_busy", o_busy, 0);
        @(negedge clk);
        chk("both_err_pulse", o_err, 0);
        chk("both_ack_late", o_ack, 0);
        op(1'b1, 1'b0, 16'h0003, 16'h0000);

        // Out of range, including a high address that would alias to word 5.
        op(1'b1, 1'b0, 16'h0100, 16'h0000);
        op(1'b0, 1'b1, 16'h0100, 16'hFFFF);
        op(1'b1, 1'b0, 16'h0005, 16'h0000);
        op(1'b0, 1'b1, 16'h8005, 16'hDEAD);
        op(1'b1, 1'b0, 16'h8005, 16'h0000);
        for (int i = 0; i < 256; i++) op(1'b1, 1'b0, 16'(i), 16'h0000);

        // Instance B: long latencies.
        sel = 1'b1;
        op(1'b0, 1'b1, 16'h0007, 16'h5555);
        op(1'b0, 1'b1, 16'h0009, 16'h1111);

        // Write strobe while a read is in flight must be dropped.
        issue(1'b1, 1'b0, 16'h0007, 16'h0000);
        step_clear();
        chk("busy_inflight", o_busy, 1);
        wr_i = 1'b1; addr_i = 16'h0007; wdata_i = 16'hAAAA;
        @(negedge clk);
        wr_i = 1'b0;
        wait_resp(4, 2);
        @(negedge clk);
        chk("drop_ack", o_ack, 0);
        chk("drop_err", o_err, 0);
        op(1'b1, 1'b0, 16'h0007, 16'h0000);

        // Reset in the middle of a WR_LAT=3 write aborts it.
        wr_i = 1'b1; addr_i = 16'h0009; wdata_i = 16'h2222;
        step_clear();
        chk("abort_busy", o_busy, 1);
        rst_b = 1'b1;
        #1;
        chk("abort_rdata", o_rdata, 0);
        chk("abort_ack", o_ack, 0);
        chk("abort_busy_rst", o_busy, 0);
        chk("abort_err", o_err, 0);
        lastd[1] = 16'd0;
        @(negedge clk);
        @(negedge clk);
        chk("abort_no_ack", o_ack, 0);
        rst_b = 1'b0;
        @(negedge clk);
        op(1'b1, 1'b0, 16'h0009, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
